// File: rtl/mux_nto1_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_nto1_arb_if
// Purpose  : N-channel valid/ready input bundle plus registered output port
//            shared between producers, the arbitrating mux and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_nto1_arb_if #(
    parameter int WORD_LENGTH = 32,
    parameter int NUM_INPUTS  = 4,
    parameter int SEL_WIDTH   = 2
);
    logic [NUM_INPUTS-1:0]             in_valid;
    logic [NUM_INPUTS*WORD_LENGTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]             in_ready;
    logic                              force_sel_en;
    logic [SEL_WIDTH-1:0]              force_sel;
    logic                              out_valid;
    logic [WORD_LENGTH-1:0]            out_data;
    logic [SEL_WIDTH-1:0]              out_sel;
    logic                              out_ready;

    modport master (
        output in_valid, in_data, force_sel_en, force_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, force_sel_en, force_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface
`default_nettype wire

// File: rtl/mux_nto1_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux_nto1_arb
// Purpose  : N-to-1 registered mux with round-robin / fixed-priority
//            arbitration and an explicit selector override.
// Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_arb #(
    parameter int WORD_LENGTH   = 32,
    parameter int NUM_INPUTS    = 4,
    parameter int SEL_WIDTH     = 2,
    parameter int PRIORITY_MODE = 0
) (
    input  logic               clk,
    input  logic               reset,
    mux_nto1_arb_if.slave      bus
);
    localparam logic [NUM_INPUTS-1:0] c_one = {{(NUM_INPUTS-1){1'b0}}, 1'b1};

    logic [SEL_WIDTH-1:0]    r_rr_ptr;
    logic                    r_out_valid;
    logic [WORD_LENGTH-1:0]  r_out_data;
    logic [SEL_WIDTH-1:0]    r_out_sel;

    logic                    w_load_en;
    logic [NUM_INPUTS-1:0]   w_elig;
    logic [SEL_WIDTH-1:0]    w_start;
    logic [2*NUM_INPUTS-1:0] w_dbl;
    logic [NUM_INPUTS-1:0]   w_rot;
    logic                    w_gvalid;
    logic [SEL_WIDTH-1:0]    w_gidx;
    logic [NUM_INPUTS-1:0]   w_grant;
    logic [WORD_LENGTH-1:0]  w_gdata;

    assign w_load_en = !r_out_valid || bus.out_ready;
    assign w_start   = (PRIORITY_MODE != 0) ? '0 : r_rr_ptr;

    // An out-of-range forced index never matches any channel, so E is empty.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (bus.force_sel_en)
                w_elig[i] = bus.in_valid[i] && (int'(bus.force_sel) == i);
            else
                w_elig[i] = bus.in_valid[i];
        end
    end

    // Rotate E so the search always starts at bit 0, then undo the rotation.
    assign w_dbl = {w_elig, w_elig} >> w_start;
    assign w_rot = w_dbl[NUM_INPUTS-1:0];

    always_comb begin
        int sum;
        sum      = 0;
        w_gvalid = 1'b0;
        w_gidx   = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!w_gvalid && w_rot[k]) begin
                sum = int'(w_start) + k;
                if (sum >= NUM_INPUTS)
                    sum = sum - NUM_INPUTS;
                w_gvalid = 1'b1;
                w_gidx   = SEL_WIDTH'(sum);
            end
        end
    end

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (w_gidx == SEL_WIDTH'(i))
                w_gdata = bus.in_data[i*WORD_LENGTH +: WORD_LENGTH];
        end
    end

    assign w_grant      = w_gvalid ? (c_one << w_gidx) : '0;
    assign bus.in_ready = (w_load_en && !reset) ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load_en) begin
            if (w_gvalid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gdata;
                r_out_sel   <= w_gidx;
                if (PRIORITY_MODE == 0 && !bus.force_sel_en)
                    r_rr_ptr <= (int'(w_gidx) == NUM_INPUTS - 1) ? '0 : w_gidx + 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_nto1_arb
// Purpose  : Self-checking bench: 4-in RR, 3-in RR and 4-in fixed-priority
//            instances driven by scenario tasks against a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_arb;
    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    mux_nto1_arb_if #(.WORD_LENGTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2)) ifa ();
    mux_nto1_arb_if #(.WORD_LENGTH(32), .NUM_INPUTS(3), .SEL_WIDTH(2)) ifb ();
    mux_nto1_arb_if #(.WORD_LENGTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2)) ifc ();

    mux_nto1_arb #(.WORD_LENGTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2), .PRIORITY_MODE(0))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mux_nto1_arb #(.WORD_LENGTH(32), .NUM_INPUTS(3), .SEL_WIDTH(2), .PRIORITY_MODE(0))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    mux_nto1_arb #(.WORD_LENGTH(32), .NUM_INPUTS(4), .SEL_WIDTH(2), .PRIORITY_MODE(1))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic setup_a();
        ifa.force_sel_en = 1'b0;
        ifa.force_sel    = 2'd0;
        ifa.in_valid     = 4'hF;
        ifa.out_ready    = 1'b1;
        for (int i = 0; i < 4; i++) ifa.in_data[i*32 +: 32] = 32'hA0 + i;
    endtask

    task automatic test_reset();
        setup_a();
        reset = 1'b1;
        repeat (2) begin
            tick();
            tests_run++;
            if (ifa.in_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL reset_in_ready: got %b expected 0000", ifa.in_ready);
            end
        end
        tests_run++;
        if ({ifa.out_valid, ifa.out_sel, ifa.out_data} !== {1'b0, 2'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b s=%0d d=%h expected v=0 s=0 d=0",
                     ifa.out_valid, ifa.out_sel, ifa.out_data);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (ifa.in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got %b expected 0001", ifa.in_ready);
        end
        exp_q.push_back('{sel: 2'd0, data: 32'hA0});
        tick();
        tests_run++;
        e = exp_q.pop_front();
        if ({ifa.out_valid, ifa.out_sel, ifa.out_data} !== {1'b1, e.sel, e.data}) begin
            tests_failed++;
            $display("FAIL reset_first_word: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                     ifa.out_valid, ifa.out_sel, ifa.out_data, e.sel, e.data);
        end
    endtask

    task automatic test_round_robin4();
        setup_a();
        apply_reset(1);
        for (int i = 0; i < 9; i++) exp_q.push_back('{sel: 2'(i % 4), data: 32'hA0 + (i % 4)});
        repeat (9) begin
            tick();
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rr4_seq: got output with empty scoreboard expected none");
            end else begin
                e = exp_q.pop_front();
                if ({ifa.out_valid, ifa.out_sel, ifa.out_data} !== {1'b1, e.sel, e.data}) begin
                    tests_failed++;
                    $display("FAIL rr4_seq: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                             ifa.out_valid, ifa.out_sel, ifa.out_data, e.sel, e.data);
                end
            end
        end
    endtask

    task automatic test_round_robin3();
        ifb.force_sel_en = 1'b0;
        ifb.force_sel    = 2'd0;
        ifb.in_valid     = 3'b111;
        ifb.out_ready    = 1'b1;
        for (int i = 0; i < 3; i++) ifb.in_data[i*32 +: 32] = 32'hB0 + i;
        apply_reset(1);
        for (int i = 0; i < 7; i++) exp_q.push_back('{sel: 2'(i % 3), data: 32'hB0 + (i % 3)});
        repeat (7) begin
            tick();
            tests_run++;
            e = exp_q.pop_front();
            if ({ifb.out_valid, ifb.out_sel, ifb.out_data} !== {1'b1, e.sel, e.data}) begin
                tests_failed++;
                $display("FAIL rr3_seq: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                         ifb.out_valid, ifb.out_sel, ifb.out_data, e.sel, e.data);
            end
        end
        // Out-of-range forced index must leave the eligible set empty.
        ifb.force_sel_en = 1'b1;
        ifb.force_sel    = 2'd3;
        #1;
        tests_run++;
        if (ifb.in_ready !== 3'b000) begin
            tests_failed++;
            $display("FAIL rr3_force_oob: got %b expected 000", ifb.in_ready);
        end
        ifb.force_sel_en = 1'b0;
    endtask

    task automatic test_fixed_priority();
        ifc.force_sel_en = 1'b0;
        ifc.force_sel    = 2'd0;
        ifc.in_valid     = 4'b0110;
        ifc.out_ready    = 1'b1;
        for (int i = 0; i < 4; i++) ifc.in_data[i*32 +: 32] = 32'hC0 + i;
        apply_reset(1);
        repeat (4) begin
            exp_q.push_back('{sel: 2'd1, data: 32'hC1});
            #1;
            tests_run++;
            if (ifc.in_ready !== 4'b0010) begin
                tests_failed++;
                $display("FAIL prio_ready: got %b expected 0010", ifc.in_ready);
            end
            tick();
            tests_run++;
            e = exp_q.pop_front();
            if ({ifc.out_valid, ifc.out_sel, ifc.out_data} !== {1'b1, e.sel, e.data}) begin
                tests_failed++;
                $display("FAIL prio_ch1: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                         ifc.out_valid, ifc.out_sel, ifc.out_data, e.sel, e.data);
            end
        end
        ifc.in_valid = 4'b0100;
        exp_q.push_back('{sel: 2'd2, data: 32'hC2});
        tick();
        tests_run++;
        e = exp_q.pop_front();
        if ({ifc.out_valid, ifc.out_sel, ifc.out_data} !== {1'b1, e.sel, e.data}) begin
            tests_failed++;
            $display("FAIL prio_ch2: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                     ifc.out_valid, ifc.out_sel, ifc.out_data, e.sel, e.data);
        end
    endtask

    task automatic test_back_pressure();
        setup_a();
        apply_reset(1);
        tick();
        tick();
        ifa.out_ready = 1'b0;
        repeat (3) begin
            #1;
            tests_run++;
            if (ifa.in_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_ready: got %b expected 0000", ifa.in_ready);
            end
            tick();
            tests_run++;
            if ({ifa.out_valid, ifa.out_sel, ifa.out_data} !== {1'b1, 2'd1, 32'hA1}) begin
                tests_failed++;
                $display("FAIL bp_hold: got v=%b s=%0d d=%h expected v=1 s=1 d=a1",
                         ifa.out_valid, ifa.out_sel, ifa.out_data);
            end
        end
        ifa.out_ready = 1'b1;
        #1;
        tests_run++;
        if (ifa.in_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b expected 0100", ifa.in_ready);
        end
        exp_q.push_back('{sel: 2'd2, data: 32'hA2});
        tick();
        tests_run++;
        e = exp_q.pop_front();
        if ({ifa.out_valid, ifa.out_sel, ifa.out_data} !== {1'b1, e.sel, e.data}) begin
            tests_failed++;
            $display("FAIL bp_release_word: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                     ifa.out_valid, ifa.out_sel, ifa.out_data, e.sel, e.data);
        end
    endtask

    task automatic test_forced_select();
        setup_a();
        apply_reset(1);
        ifa.force_sel_en = 1'b1;
        ifa.force_sel    = 2'd2;
        repeat (3) begin
            exp_q.push_back('{sel: 2'd2, data: 32'hA2});
            #1;
            tests_run++;
            if (ifa.in_ready !== 4'b0100) begin
                tests_failed++;
                $display("FAIL force_ready: got %b expected 0100", ifa.in_ready);
            end
            tick();
            tests_run++;
            e = exp_q.pop_front();
            if ({ifa.out_valid, ifa.out_sel, ifa.out_data} !== {1'b1, e.sel, e.data}) begin
                tests_failed++;
                $display("FAIL force_word: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                         ifa.out_valid, ifa.out_sel, ifa.out_data, e.sel, e.data);
            end
        end
        ifa.in_valid = 4'b1011;
        #1;
        tests_run++;
        if (ifa.in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL force_idle_ready: got %b expected 0000", ifa.in_ready);
        end
        tick();
        tests_run++;
        if (ifa.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL force_idle_valid: got %b expected 0", ifa.out_valid);
        end
        // Forced transfers must not have advanced the round-robin pointer.
        ifa.force_sel_en = 1'b0;
        ifa.in_valid     = 4'hF;
        #1;
        tests_run++;
        if (ifa.in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL force_rr_kept: got %b expected 0001", ifa.in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        setup_a();
        apply_reset(1);
        tick();
        tick();
        ifa.out_ready = 1'b0;
        reset = 1'b1;
        tick();
        tests_run++;
        if ({ifa.out_valid, ifa.out_sel, ifa.out_data} !== {1'b0, 2'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got v=%b s=%0d d=%h expected v=0 s=0 d=0",
                     ifa.out_valid, ifa.out_sel, ifa.out_data);
        end
        reset = 1'b0;
        ifa.out_ready = 1'b1;
        #1;
        tests_run++;
        if (ifa.in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL midreset_rr_ptr: got %b expected 0001", ifa.in_ready);
        end
        exp_q.push_back('{sel: 2'd0, data: 32'hA0});
        tick();
        tests_run++;
        e = exp_q.pop_front();
        if ({ifa.out_valid, ifa.out_sel, ifa.out_data} !== {1'b1, e.sel, e.data}) begin
            tests_failed++;
            $display("FAIL midreset_word: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                     ifa.out_valid, ifa.out_sel, ifa.out_data, e.sel, e.data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifb.in_valid = '0; ifb.in_data = '0; ifb.force_sel_en = 1'b0;
        ifb.force_sel = '0; ifb.out_ready = 1'b1;
        ifc.in_valid = '0; ifc.in_data = '0; ifc.force_sel_en = 1'b0;
        ifc.force_sel = '0; ifc.out_ready = 1'b1;
        setup_a();
        #2;
        test_reset();
        test_round_robin4();
        test_round_robin3();
        test_fixed_priority();
        test_back_pressure();
        test_forced_select();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mux_nto1_arb.md
# mux_nto1_arb

Parametrised N-input, registered multiplexer with per-channel valid/ready handshaking and arbitration; the next generation of the team's fixed-width selector muxes. It is used where several producers (ALU result, memory read data, PC-derived values, immediates) contend for one datapath consumer across cycles instead of being chosen combinationally. Selection is by round-robin or fixed-priority arbitration, or by an explicit selector override that preserves the legacy select-by-index usage. One output register stage decouples the consumer's timing from the producers.

## Interface
- WORD_LENGTH, 32, data width of every channel and of the output
- NUM_INPUTS, 4, number of input channels, 2..16
- SEL_WIDTH, 2, selector/index width; must equal ceil(log2(NUM_INPUTS))
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  NUM_INPUTS  bit i: channel i presents a word
- in_data  input  NUM_INPUTS*WORD_LENGTH  channel i data at bits [i*WORD_LENGTH +: WORD_LENGTH]
- in_ready  output  NUM_INPUTS  bit i: channel i word is accepted this cycle (one-hot or zero)
- force_sel_en  input  1  1 = bypass arbitration; only channel force_sel is eligible
- force_sel  input  SEL_WIDTH  forced channel index
- out_valid  output  1  output register holds a valid word
- out_data  output  WORD_LENGTH  registered data
- out_sel  output  SEL_WIDTH  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Transfer on channel i when in_valid[i] && in_ready[i]. Transfer on the output when out_valid && out_ready.
- load_en = !out_valid || out_ready. This means the register is empty, or it is draining this cycle.
- Eligible set E:
  - force_sel_en=1: E = {force_sel} if in_valid[force_sel] and force_sel < NUM_INPUTS, otherwise empty.
  - force_sel_en=0: E = all i with in_valid[i].
- Grant: one-hot over E, zero if E is empty.
  - PRIORITY_MODE=1: lowest index in E.
  - PRIORITY_MODE=0: first index in E at or after rr_ptr, searching upward modulo NUM_INPUTS.
- in_ready = grant when load_en=1, otherwise all zero. in_ready is combinational from in_valid, force_sel_en, force_sel, out_valid, out_ready and rr_ptr.
- On a cycle with load_en=1 and a nonzero grant on index g:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
- On a cycle with load_en=1 and a zero grant, out_valid <= 0. out_data and out_sel hold their values.
- When load_en=0, all output registers hold.
- rr_ptr (SEL_WIDTH bits):
  - On a non-forced input transfer on index g: rr_ptr <= (g+1) mod NUM_INPUTS. Wrap from NUM_INPUTS-1 goes to 0, including when NUM_INPUTS is not a power of 2.
  - Forced transfers and idle cycles leave rr_ptr unchanged.
  - In PRIORITY_MODE=1, rr_ptr is unused and stays 0.
- in_valid without in_ready is a stall. The producer keeps its data stable; the block has no requirement on a producer dropping valid.

## Timing
- Reset values (first edge with reset=1): out_valid=0, out_data=0, out_sel=0, rr_ptr=0.
- in_ready is all zero whenever reset=1.
- Reset has priority over any transfer in the same cycle. A word held in the register at reset is discarded.
- Latency: 1 cycle. A word accepted at edge k is on out_data with out_valid=1 after edge k.
- Throughput: 1 word/cycle with out_ready held at 1.
- Simultaneous drain and load: when out_valid && out_ready and an input transfer occur in the same cycle, the register is replaced with no bubble.
- Back-pressure: out_ready=0 with out_valid=1 holds out_data/out_sel and forces in_ready=0. The in_ready path passes combinationally from out_ready.
- Selector changes (force_sel_en, force_sel) take effect in the same cycle; no latched selector state.

## Test plan
- Reset behaviour: NUM_INPUTS=4, PRIORITY_MODE=0, assert reset for 2 cycles with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0. After release, the first grant goes to ch0.
- Round-robin fairness: all 4 in_valid=1, in_data[i]=0xA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0,… with out_data 0xA0,0xA1,0xA2,0xA3,0xA0, one per cycle, no bubbles. Repeat with NUM_INPUTS=3 -> sequence 0,1,2,0 (wrap at 3).
- Fixed priority: PRIORITY_MODE=1, in_valid=0110 -> ch1 granted every cycle and ch2 never. Drop ch1's in_valid -> ch2 granted the next cycle.
- Back-pressure: out_valid=1 holding 0xA1, out_ready=0 for 3 cycles -> out_data stays 0xA1 and in_ready=0000. out_ready=1 -> the next word is loaded in the same cycle the held word drains.
- Forced select: force_sel_en=1, force_sel=2, in_valid=1111 -> only in_ready[2]=1 and out_sel=2 each cycle, rr_ptr unchanged. force_sel=2 with in_valid[2]=0 -> in_ready=0000 and out_valid falls to 0 after the drain.
- Reset mid-operation: reset=1 while out_valid=1 and out_ready=0 -> out_valid=0 after the edge, the held word is lost, and rr_ptr returns to 0.
